// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: programmable clock divider with run/stop/single-step control
// and a debounced step push-button.
module clock_div_ctrl #(
  parameter int CNT_W        = 23,
  parameter int HALF_DEFAULT = 5999999,
  parameter int DB_CYCLES    = 120000
) (
  input  logic             clock_in,
  input  logic             nReset,
  input  logic [1:0]       mode,
  input  logic [CNT_W-1:0] half_period,
  input  logic             load,
  input  logic             step_btn,
  output logic             clock_out,
  output logic             tick,
  output logic             busy
);
  localparam int DB_W = $clog2(DB_CYCLES + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);
  localparam logic [2:0] IDLE = 3'd0, RUN = 3'd1, STOPPING = 3'd2, STEP_HI = 3'd3, STEP_LO = 3'd4;
  logic [2:0]       state;
  logic [CNT_W-1:0] count, half_reg, cnt_nxt;
  logic [1:0]       sync;
  logic [DB_W-1:0]  db_cnt;
  logic             acc, acc_d, step_evt, phase_end, run_mode;
  assign phase_end = count >= half_reg;
  assign cnt_nxt   = phase_end ? '0 : count + 1'b1;
  assign step_evt  = acc & ~acc_d;
  assign run_mode  = mode == 2'b01;
  assign busy      = state != IDLE;
  always_ff @(posedge clock_in or negedge nReset)
    if (!nReset) begin
      sync   <= '0;
      acc    <= 1'b0;
      acc_d  <= 1'b0;
      db_cnt <= '0;
    end else begin
      sync  <= {sync[0], step_btn};
      acc_d <= acc;
      if (sync[1] == acc) db_cnt <= '0;
      else if (db_cnt == DB_LAST) begin
        acc    <= sync[1];
        db_cnt <= '0;
      end else db_cnt <= db_cnt + 1'b1;
    end
  always_ff @(posedge clock_in or negedge nReset)
    if (!nReset) half_reg <= CNT_W'(HALF_DEFAULT);
    else if (load) half_reg <= half_period;
  always_ff @(posedge clock_in or negedge nReset)
    if (!nReset) begin
      state     <= IDLE;
      count     <= '0;
      clock_out <= 1'b0;
      tick      <= 1'b0;
    end else begin
      tick <= 1'b0;
      case (state)
        IDLE: begin
          count <= '0;
          if (run_mode) state <= RUN;
          else if (mode == 2'b10 && step_evt) begin
            state     <= STEP_HI;
            clock_out <= 1'b1;
            tick      <= 1'b1;
          end
        end
        RUN: begin
          count <= cnt_nxt;
          if (!run_mode && !clock_out) begin
            state <= IDLE;
            count <= '0;
          end else if (phase_end) begin
            clock_out <= ~clock_out;
            tick      <= ~clock_out;
            if (!run_mode) state <= IDLE;
          end else if (!run_mode) state <= STOPPING;
        end
        STOPPING, STEP_HI: begin
          count <= cnt_nxt;
          if (phase_end) begin
            clock_out <= 1'b0;
            state     <= state == STEP_HI ? STEP_LO : IDLE;
          end
        end
        STEP_LO: begin
          count <= cnt_nxt;
          if (phase_end) state <= IDLE;
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          clock_out <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb_clock_div_ctrl: directed checks of run, reload, stop, step and reset behaviour.
module tb_clock_div_ctrl;
  localparam int CNT_W = 8;
  logic             clock_in = 1'b0;
  logic             nReset = 1'b0;
  logic [1:0]       mode = 2'b00;
  logic [CNT_W-1:0] half_period = '0;
  logic             load = 1'b0;
  logic             step_btn = 1'b0;
  logic             clock_out, tick, busy;
  int passed = 0, total = 0;
  int first, ticks, hi, bsy;

  clock_div_ctrl #(.CNT_W(CNT_W), .HALF_DEFAULT(3), .DB_CYCLES(4)) dut (
    .clock_in(clock_in), .nReset(nReset), .mode(mode), .half_period(half_period),
    .load(load), .step_btn(step_btn), .clock_out(clock_out), .tick(tick), .busy(busy)
  );

  always #5 clock_in = ~clock_in;

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clock_in);
      #1;
    end
  endtask

  // Runs n cycles; first = 1-based cycle of first tick (-1 if none).
  task automatic watch(input int n, output int f, output int t, output int h, output int b);
    f = -1; t = 0; h = 0; b = 0;
    for (int i = 1; i <= n; i++) begin
      cyc();
      if (tick) begin
        t++;
        if (f < 0) f = i;
      end
      h += int'(clock_out);
      b += int'(busy);
    end
  endtask

  task automatic wait_tick(input string tag, input int max);
    int n = 0;
    while (!tick && n < max) begin
      cyc();
      n++;
    end
    chk(tag, int'(tick), 1);
  endtask

  task automatic load_half(input int v);
    half_period = CNT_W'(v);
    load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst_clk", int'(clock_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_busy", int'(busy), 0);
    cyc(2);
    nReset = 1'b1;
    cyc(3);
    chk("idle_busy", int'(busy), 0);

    // run at the reset half-period of 3
    mode = 2'b01;
    cyc();
    chk("run_busy", int'(busy), 1);
    watch(4, first, ticks, hi, bsy);
    chk("run_first_tick", first, 4);
    chk("run_clk_hi", int'(clock_out), 1);
    watch(16, first, ticks, hi, bsy);
    chk("run_period", first, 8);
    chk("run_ticks", ticks, 2);
    chk("run_duty", hi, 8);

    // stop during a high phase at count 1
    cyc();
    mode = 2'b00;
    cyc();
    chk("stop_hold1", int'(clock_out), 1);
    chk("stop_busy", int'(busy), 1);
    mode = 2'b01;
    cyc();
    chk("stop_hold2", int'(clock_out), 1);
    mode = 2'b00;
    cyc();
    chk("stop_low", int'(clock_out), 0);
    chk("stop_idle", int'(busy), 0);
    watch(20, first, ticks, hi, bsy);
    chk("stop_no_ticks", ticks, 0);
    chk("stop_no_hi", hi, 0);

    // reload to 1 while count=3 with half_reg=5
    load_half(5);
    mode = 2'b01;
    cyc();
    watch(6, first, ticks, hi, bsy);
    chk("reload_first", first, 6);
    cyc(3);
    half_period = 8'd1;
    load = 1'b1;
    cyc();
    load = 1'b0;
    chk("reload_pre", int'(clock_out), 1);
    cyc();
    chk("reload_end", int'(clock_out), 0);
    watch(8, first, ticks, hi, bsy);
    chk("reload_first2", first, 2);
    chk("reload_ticks", ticks, 2);
    chk("reload_hi", hi, 4);
    mode = 2'b00;
    cyc(6);
    chk("reload_stop", int'(busy), 0);

    // half_period 0: divide by two
    load_half(0);
    mode = 2'b01;
    cyc();
    watch(10, first, ticks, hi, bsy);
    chk("div2_first", first, 1);
    chk("div2_ticks", ticks, 5);
    chk("div2_hi", hi, 5);
    mode = 2'b00;
    cyc(4);
    chk("div2_stop", int'(busy), 0);
    chk("div2_low", int'(clock_out), 0);
    load_half(3);

    // bouncing press in step mode yields exactly one pulse
    mode = 2'b10;
    step_btn = 1'b1;
    cyc();
    step_btn = 1'b0;
    cyc();
    step_btn = 1'b1;
    watch(40, first, ticks, hi, bsy);
    chk("step_ticks", ticks, 1);
    chk("step_hi", hi, 4);
    chk("step_busy", bsy, 8);
    step_btn = 1'b0;
    watch(12, first, ticks, hi, bsy);
    chk("step_release", ticks, 0);

    // second press accepted during a longer pulse is discarded
    load_half(7);
    step_btn = 1'b1;
    wait_tick("step2_tick", 20);
    step_btn = 1'b0;
    cyc(7);
    step_btn = 1'b1;
    watch(40, first, ticks, hi, bsy);
    chk("step2_no_extra", ticks, 0);
    chk("step2_busy", bsy, 8);
    chk("step2_idle", int'(busy), 0);
    step_btn = 1'b0;
    load_half(3);
    cyc(12);

    // reset mid STEP_HI
    step_btn = 1'b1;
    wait_tick("rst_step_tick", 20);
    cyc();
    chk("rst_step_hi", int'(clock_out), 1);
    #2 nReset = 1'b0;
    #1;
    chk("rst_async_clk", int'(clock_out), 0);
    chk("rst_async_busy", int'(busy), 0);
    mode = 2'b00;
    cyc(2);
    nReset = 1'b1;
    watch(100, first, ticks, hi, bsy);
    chk("rst_after_hi", hi, 0);
    chk("rst_after_ticks", ticks, 0);
    chk("rst_after_busy", bsy, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
